// File: rtl/fm_radio_pkg.sv
// Shared constants and helpers for the FM receive chain datapath.
// Holds the default quantized sample width and fraction bits, plus the
// reference quantize function that matches the software model.
package fm_radio_pkg;

    // Default width of a quantized sample word.
    localparam int FM_DATA_WIDTH = 32;

    // Default number of fixed-point fraction bits (quantization shift).
    localparam int FM_BITS = 10;

    // Sign-extend a raw 16-bit sample and scale it into fixed point.
    function automatic logic [FM_DATA_WIDTH-1:0] quantize(input logic signed [15:0] sample);
        return FM_DATA_WIDTH'(sample) <<< FM_BITS;
    endfunction

endpackage

// File: rtl/read_iq_if.sv
// FIFO-side signal bundle for read_iq: the raw byte input FIFO (read side)
// and the I/Q sample FIFOs (write side).
// master: the read_iq stage. slave: the surrounding FIFOs.
interface read_iq_if
    import fm_radio_pkg::*;
#(
    parameter int DATA_WIDTH = FM_DATA_WIDTH
);
    logic [7:0]            in_dout;
    logic                  in_empty;
    logic                  in_rd_en;
    logic [DATA_WIDTH-1:0] i_din;
    logic                  i_full;
    logic                  i_wr_en;
    logic [DATA_WIDTH-1:0] q_din;
    logic                  q_full;
    logic                  q_wr_en;

    modport master (
        input  in_dout, in_empty, i_full, q_full,
        output in_rd_en, i_din, i_wr_en, q_din, q_wr_en
    );

    modport slave (
        output in_dout, in_empty, i_full, q_full,
        input  in_rd_en, i_din, i_wr_en, q_din, q_wr_en
    );
endinterface

// File: rtl/read_iq.sv
// read_iq: pops interleaved little-endian I/Q bytes (I_lo, I_hi, Q_lo, Q_hi)
// from the byte FIFO, quantizes each 16-bit sample (sign-extend, << BITS)
// and writes the pair atomically into the I and Q sample FIFOs.
// Optional feature macro: READ_IQ_STATS_EN adds the pair_count output.
module read_iq
    import fm_radio_pkg::*;
#(
    parameter int DATA_WIDTH = FM_DATA_WIDTH,
    parameter int BITS       = FM_BITS
)(
    input  logic      clock,
    input  logic      reset,
    read_iq_if.master bus
`ifdef READ_IQ_STATS_EN
    ,
    output logic [31:0] pair_count
`endif
);

    generate
        if (DATA_WIDTH < 16 + BITS) begin : g_width_check
            $error("read_iq: DATA_WIDTH must be at least 16 + BITS");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_I_LO,
        S_I_HI,
        S_Q_LO,
        S_Q_HI,
        S_WRITE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] i_lo;
    logic [7:0] i_hi;
    logic [7:0] q_lo;
    logic       pop;
    logic       write;

    // Sign-extend a 16-bit sample to the datapath width, then scale.
    function automatic logic [DATA_WIDTH-1:0] scale(input logic [15:0] word);
        return {{(DATA_WIDTH-16){word[15]}}, word} << BITS;
    endfunction

    // State register; an async reset drops any partially assembled pair.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of block ordering.
        if (reset) state <= S_I_LO;
        else       state <= state_next;
    end

    // Next-state logic and the combinational pop/write strobes.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case can leave a signal unassigned and infer a latch.
        state_next = state;
        pop        = 1'b0;
        write      = 1'b0;
        case (state)
            S_I_LO: if (!bus.in_empty) begin pop = 1'b1; state_next = S_I_HI;  end
            S_I_HI: if (!bus.in_empty) begin pop = 1'b1; state_next = S_Q_LO;  end
            S_Q_LO: if (!bus.in_empty) begin pop = 1'b1; state_next = S_Q_HI;  end
            S_Q_HI: if (!bus.in_empty) begin pop = 1'b1; state_next = S_WRITE; end
            S_WRITE: begin
                // Both FIFOs must have room: a pair is never split.
                if (!bus.i_full && !bus.q_full) begin
                    write      = 1'b1;
                    state_next = S_I_LO;
                end
            end
            default: state_next = S_I_LO;
        endcase
    end

    assign bus.in_rd_en = pop;
    assign bus.i_wr_en  = write;
    assign bus.q_wr_en  = write;

    // Byte capture and sample quantization; Q_hi is used straight from the
    // FIFO head so the pair is ready the cycle after the last pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            i_lo      <= '0;
            i_hi      <= '0;
            q_lo      <= '0;
            bus.i_din <= '0;
            bus.q_din <= '0;
        end else if (pop) begin
            case (state)
                S_I_LO: i_lo <= bus.in_dout;
                S_I_HI: i_hi <= bus.in_dout;
                S_Q_LO: q_lo <= bus.in_dout;
                S_Q_HI: begin
                    bus.i_din <= scale({i_hi, i_lo});
                    bus.q_din <= scale({bus.in_dout, q_lo});
                end
                default: ;
            endcase
        end
    end

`ifdef READ_IQ_STATS_EN
    logic [31:0] pair_count_q;

    // Count written pairs; wraps naturally at 2^32.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)            pair_count_q <= '0;
        else if (bus.i_wr_en) pair_count_q <= pair_count_q + 32'd1;
    end

    assign pair_count = pair_count_q;
`endif

endmodule

// File: tb/tb_read_iq.sv
// Directed testbench for read_iq: a byte-queue model of the input FIFO,
// logged pops/writes with cycle stamps, and per-scenario checks.
module tb_read_iq;

    logic clock;
    logic reset;

    read_iq_if bus ();

`ifdef READ_IQ_STATS_EN
    logic [31:0] pair_count;
`endif

    read_iq dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef READ_IQ_STATS_EN
        ,
        .pair_count (pair_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]  src[$];
    logic        gate_empty = 1'b0;
    int          cyc;
    int          proto_err;
    int          pop_cyc[$];
    logic [7:0]  pop_byte[$];
    int          wr_cyc[$];
    logic [31:0] wr_i[$];
    logic [31:0] wr_q[$];

    // Bench model of quantization with DATA_WIDTH=32, BITS=10.
    function automatic logic [31:0] model_q(input logic [15:0] w);
        logic [31:0] ext;
        ext = {{16{w[15]}}, w};
        return ext << 10;
    endfunction

    task automatic clear_logs();
        cyc = 0;
        proto_err = 0;
        pop_cyc.delete();
        pop_byte.delete();
        wr_cyc.delete();
        wr_i.delete();
        wr_q.delete();
    endtask

    task automatic push_pair(input logic [15:0] i16, input logic [15:0] q16);
        src.push_back(i16[7:0]);
        src.push_back(i16[15:8]);
        src.push_back(q16[7:0]);
        src.push_back(q16[15:8]);
    endtask

    // One clock cycle: present FIFO head, sample strobes away from the edge,
    // then apply the pop at the edge.
    task automatic cycle();
        logic do_pop;
        bus.in_empty = gate_empty || (src.size() == 0);
        bus.in_dout  = (src.size() != 0) ? src[0] : 8'h00;
        #1;
        if (bus.in_rd_en && bus.in_empty) proto_err++;
        if (bus.i_wr_en !== bus.q_wr_en) proto_err++;
        if (bus.i_wr_en && (bus.i_full || bus.q_full)) proto_err++;
        if (bus.in_rd_en && bus.i_wr_en) proto_err++;
        if (bus.in_rd_en) begin
            pop_cyc.push_back(cyc);
            pop_byte.push_back(bus.in_dout);
        end
        if (bus.i_wr_en) begin
            wr_cyc.push_back(cyc);
            wr_i.push_back(bus.i_din);
            wr_q.push_back(bus.q_din);
        end
        do_pop = bus.in_rd_en;
        @(posedge clock);
        #1;
        if (do_pop) void'(src.pop_front());
        cyc++;
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic run_until_writes(input int target, input int budget);
        int left;
        left = budget;
        while (wr_cyc.size() < target && left > 0) begin
            cycle();
            left--;
        end
        tests_run++;
        if (wr_cyc.size() < target) begin
            tests_failed++;
            $display("FAIL timeout: writes seen %0d, required %0d", wr_cyc.size(), target);
        end
    endtask

    task automatic check_pair(input string name, input int idx,
                              input logic [31:0] exp_i, input logic [31:0] exp_q);
        tests_run++;
        if (wr_cyc.size() <= idx) begin
            tests_failed++;
            $display("FAIL %s: write %0d missing", name, idx);
        end else if (wr_i[idx] !== exp_i || wr_q[idx] !== exp_q) begin
            tests_failed++;
            $display("FAIL %s: got i=%h q=%h, required i=%h q=%h",
                     name, wr_i[idx], wr_q[idx], exp_i, exp_q);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run_cycles(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        src.delete();
        bus.i_full = 1'b0;
        bus.q_full = 1'b0;
        bus.in_empty = 1'b1;
        bus.in_dout = 8'h00;
        reset = 1'b1;
        #3;
        tests_run++;
        if (bus.i_din !== 32'h0 || bus.q_din !== 32'h0 || bus.i_wr_en !== 1'b0 ||
            bus.q_wr_en !== 1'b0 || bus.in_rd_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: i_din=%h q_din=%h wr=%b%b rd=%b, required all zero",
                     bus.i_din, bus.q_din, bus.i_wr_en, bus.q_wr_en, bus.in_rd_en);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        clear_logs();
        run_cycles(3);
        check_int("reset_idle_writes", wr_cyc.size(), 0);
    endtask

    task automatic test_basic();
        clear_logs();
        src = '{8'h34, 8'h12, 8'hCD, 8'hAB};
        run_until_writes(1, 20);
        run_cycles(3);
        check_pair("basic_pair", 0, 32'h0048D000, 32'hFEAF3400);
        check_int("basic_write_count", wr_cyc.size(), 1);
        check_int("basic_pop_count", pop_cyc.size(), 4);
        if (pop_cyc.size() == 4 && wr_cyc.size() >= 1)
            check_int("basic_latency", wr_cyc[0] - pop_cyc[3], 1);
        check_int("basic_protocol", proto_err, 0);
    endtask

    task automatic test_extremes();
        clear_logs();
        src = '{8'hFF, 8'h7F, 8'h00, 8'h80};
        run_until_writes(1, 20);
        check_pair("extremes_pair", 0, 32'h01FFFC00, 32'hFE000000);
    endtask

    task automatic test_empty_gaps();
        int held_err;
        held_err = 0;
        clear_logs();
        src = '{8'h11, 8'h22, 8'h33, 8'h44};
        gate_empty = 1'b1;
        for (int k = 0; k < 30 && wr_cyc.size() == 0; k++) begin
            if (pop_cyc.size() < 4 &&
                (bus.i_din !== 32'h01FFFC00 || bus.q_din !== 32'hFE000000)) held_err++;
            cycle();
            gate_empty = ~gate_empty;
        end
        gate_empty = 1'b0;
        run_cycles(4);
        check_pair("gaps_pair", 0, 32'h00884400, 32'h0110CC00);
        check_int("gaps_held_output", held_err, 0);
        check_int("gaps_pop_count", pop_cyc.size(), 4);
        tests_run++;
        if (pop_byte.size() != 4 || pop_byte[0] !== 8'h11 || pop_byte[1] !== 8'h22 ||
            pop_byte[2] !== 8'h33 || pop_byte[3] !== 8'h44) begin
            tests_failed++;
            $display("FAIL gaps_byte_order: %0d bytes popped, required 11 22 33 44",
                     pop_byte.size());
        end
        check_int("gaps_protocol", proto_err, 0);
    endtask

    task automatic test_full_stall();
        int held_err;
        int wr_during;
        held_err = 0;
        clear_logs();
        bus.q_full = 1'b1;
        push_pair(16'h0100, 16'hFF00);
        push_pair(16'h0002, 16'hFFFE);
        run_cycles(4);
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (bus.i_din !== 32'h00040000 || bus.q_din !== 32'hFFFC0000) held_err++;
        end
        check_int("qfull_no_write", wr_cyc.size(), 0);
        check_int("qfull_no_pop", pop_cyc.size(), 4);
        check_int("qfull_held_data", held_err, 0);
        bus.q_full = 1'b0;
        cycle();
        check_int("qfull_write_on_drop", wr_cyc.size(), 1);
        check_pair("qfull_pair", 0, 32'h00040000, 32'hFFFC0000);
        cycle();
        check_int("qfull_next_pop", pop_cyc.size(), 5);
        if (pop_cyc.size() == 5 && wr_cyc.size() == 1)
            check_int("qfull_next_pop_cycle", pop_cyc[4] - wr_cyc[0], 1);
        // Flags disagree: one full, other clear, then swapped.
        bus.i_full = 1'b1;
        run_cycles(3 + 5);
        bus.i_full = 1'b0;
        bus.q_full = 1'b1;
        run_cycles(3);
        wr_during = wr_cyc.size();
        check_int("mixed_full_no_write", wr_during, 1);
        bus.q_full = 1'b0;
        cycle();
        check_int("mixed_full_write", wr_cyc.size(), 2);
        check_pair("mixed_full_pair", 1, 32'h00000800, 32'hFFFFF800);
        check_int("full_protocol", proto_err, 0);
    endtask

    task automatic test_reset_mid();
        clear_logs();
        src = '{8'hAA, 8'hBB, 8'hCC};
        run_cycles(3);
        check_int("mid_popped_three", pop_cyc.size(), 3);
        reset = 1'b1;
        #1;
        tests_run++;
        if (bus.i_din !== 32'h0 || bus.q_din !== 32'h0 || bus.i_wr_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_values: i_din=%h q_din=%h wr=%b, required zero",
                     bus.i_din, bus.q_din, bus.i_wr_en);
        end
        run_cycles(2);
        reset = 1'b0;
        clear_logs();
        src = '{8'h01, 8'h00, 8'hFF, 8'hFF};
        run_until_writes(1, 20);
        check_pair("mid_reset_pair", 0, 32'h00000400, 32'hFFFFFC00);
    endtask

    task automatic test_back_to_back();
        localparam int N = 1000;
        int bad_gap;
        int bad_data;
        logic [15:0] iv;
        logic [15:0] qv;
        do_reset();
        clear_logs();
        for (int k = 0; k < N; k++) push_pair(16'(k * 131), 16'(-(k * 257)));
        run_until_writes(N, 5 * N + 50);
        bad_gap = 0;
        bad_data = 0;
        for (int j = 1; j < wr_cyc.size(); j++)
            if (wr_cyc[j] - wr_cyc[j-1] != 5) bad_gap++;
        for (int j = 0; j < wr_cyc.size(); j++) begin
            iv = 16'(j * 131);
            qv = 16'(-(j * 257));
            if (wr_i[j] !== model_q(iv) || wr_q[j] !== model_q(qv)) bad_data++;
        end
        check_int("b2b_write_count", wr_cyc.size(), N);
        check_int("b2b_gap_not_5", bad_gap, 0);
        check_int("b2b_bad_data", bad_data, 0);
        check_int("b2b_protocol", proto_err, 0);
`ifdef READ_IQ_STATS_EN
        check_int("b2b_pair_count", int'(pair_count), N);
`endif
    endtask

`ifdef READ_IQ_STATS_EN
    task automatic test_count_wrap();
        force dut.pair_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.pair_count_q;
        clear_logs();
        push_pair(16'h0001, 16'h0002);
        push_pair(16'h0003, 16'h0004);
        run_until_writes(2, 30);
        tests_run++;
        if (pair_count !== 32'h0) begin
            tests_failed++;
            $display("FAIL count_wrap: got %h, required 00000000", pair_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_empty_gaps();
        test_full_stall();
        test_reset_mid();
        test_back_to_back();
`ifdef READ_IQ_STATS_EN
        test_count_wrap();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
